// File: rtl/img_stream_loader.sv
// img_stream_loader: accepts a valid/ready pixel stream, writes one frame into the
// image memory in raster order, then hands the frame to the median-filter engine
// (ready/busy) and waits for it to finish before taking the next frame.
module img_stream_loader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int IMG_PIXELS = 16384,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              s_eof,
    output logic              img_we,
    output logic [ADDR_W-1:0] img_addr,
    output logic [DATA_W-1:0] img_wdata,
    output logic              mfe_ready,
    input  logic              mfe_busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_PIXELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_HANDOFF,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              img_we_q, img_we_d;
    logic [ADDR_W-1:0] img_addr_q, img_addr_d;
    logic [DATA_W-1:0] img_wdata_q, img_wdata_d;
    logic              mfe_ready_q, mfe_ready_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    // Per-beat decode shared by IDLE and FILL
    logic              accept_st;
    logic              beat;
    logic              pix_take;
    logic [ADDR_W-1:0] pix_idx;

    // Ready only while collecting pixels; held low while reset is applied
    assign accept_st = (state_q == ST_IDLE) || (state_q == ST_FILL);
    assign s_ready   = accept_st & ~reset;
    assign beat      = s_valid & s_ready;

    // Next-state, pixel write and status pulses
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        img_we_d     = 1'b0;
        img_addr_d   = img_addr_q;
        img_wdata_d  = img_wdata_q;
        mfe_ready_d  = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        pix_take     = 1'b0;
        pix_idx      = '0;

        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (beat) begin
                    // sof always (re)starts at pixel 0; a sof inside a partly
                    // filled frame is a framing error but the beat is kept
                    if (s_sof) begin
                        pix_take = 1'b1;
                        pix_idx  = '0;
                        if ((state_q == ST_FILL) && (cnt_q != '0))
                            frame_err_d = 1'b1;
                    end else if (state_q == ST_FILL) begin
                        pix_take = 1'b1;
                        pix_idx  = cnt_q;
                    end

                    if (pix_take) begin
                        img_we_d    = 1'b1;
                        img_addr_d  = pix_idx;
                        img_wdata_d = s_data;
                        if (s_eof && (pix_idx == LAST_IDX)) begin
                            state_d = ST_HANDOFF;
                            cnt_d   = '0;
                        end else if (s_eof || (pix_idx == LAST_IDX)) begin
                            // early eof or missing eof: drop the frame
                            frame_err_d = 1'b1;
                            state_d     = ST_IDLE;
                            cnt_d       = '0;
                        end else begin
                            state_d = ST_FILL;
                            cnt_d   = pix_idx + ADDR_W'(1);
                        end
                    end
                end
            end

            ST_HANDOFF: begin
                // ready is held until the filter reports busy
                if (mfe_busy) state_d = ST_RUN;
                else          mfe_ready_d = 1'b1;
            end

            ST_RUN: begin
                if (!mfe_busy) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            img_we_q     <= 1'b0;
            img_addr_q   <= '0;
            img_wdata_q  <= '0;
            mfe_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            img_we_q     <= img_we_d;
            img_addr_q   <= img_addr_d;
            img_wdata_q  <= img_wdata_d;
            mfe_ready_q  <= mfe_ready_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign img_we     = img_we_q;
    assign img_addr   = img_addr_q;
    assign img_wdata  = img_wdata_q;
    assign mfe_ready  = mfe_ready_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
